// File: rtl/fft_pkg.sv
// fft_pkg: shared types and sizes for the FFT output reorder slice
package fft_pkg;
  localparam int BIT_WIDTH = 24;
  localparam int N_PTS = 16;
  localparam int SIZE_W = 4;
  localparam int BANKS = 2;
  typedef struct packed {
    logic signed [BIT_WIDTH-1:0] re;
    logic signed [BIT_WIDTH-1:0] im;
  } sample_t;
  typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_e;
endpackage

// File: rtl/fft_output_reorder_ram.sv
// pingpong_ram: two banks of simple dual-port RAM, bank bit on top of the address
module pingpong_ram
  import fft_pkg::*;
#(
  parameter int W = 2 * BIT_WIDTH,
  parameter int AW = $clog2(BANKS) + SIZE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q, rdata_d;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/fft_output_reorder.sv
// fft_output_reorder: collects scrambled FFT bins into ping-pong banks and replays them in natural order
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH,
  parameter int N = N_PTS,
  parameter int SIZE = SIZE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  input  logic signed [bit_width-1:0] Re_i,
  input  logic signed [bit_width-1:0] Im_i,
  input  logic [SIZE-1:0]             wr_ptr_i,
  output logic signed [bit_width-1:0] Re_o,
  output logic signed [bit_width-1:0] Im_o,
  output logic [SIZE-1:0]             idx_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        last_o,
  output logic                        frame_done_o,
  output logic                        overflow_o
);
  logic [BANKS-1:0] full_q, full_d, rel, set;
  logic wr_bank_q, wr_bank_d, overflow_q, overflow_d;
  logic [SIZE:0] wr_cnt_q, wr_cnt_d;
  rd_state_e state_q, state_d;
  logic rd_bank_q, rd_bank_d, valid_q, valid_d, done_q, done_d;
  logic [SIZE-1:0] rd_idx_q, rd_idx_d, rd_addr_idx;
  logic wr_ok, acc, last_acc, rd_en;
  logic [2*bit_width-1:0] rdata;
  always_comb begin
    acc = valid_q && ready_i;
    last_acc = acc && rd_idx_q == SIZE'(N - 1);
    // releasing a bank this cycle makes it writable this cycle
    rel = last_acc ? BANKS'(1) << rd_bank_q : '0;
    wr_ok = valid_i && !(full_q[wr_bank_q] && !rel[wr_bank_q]);
    set = (wr_ok && wr_cnt_q == (SIZE+1)'(N - 1)) ? BANKS'(1) << wr_bank_q : '0;
    full_d = (full_q & ~rel) | set;
    wr_cnt_d = wr_ok ? (|set ? '0 : wr_cnt_q + 1'b1) : wr_cnt_q;
    wr_bank_d = wr_bank_q ^ (|set);
    overflow_d = overflow_q | (valid_i && !wr_ok);
    done_d = last_acc;
    state_d = state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d = rd_idx_q;
    valid_d = valid_q;
    rd_en = 1'b0;
    rd_addr_idx = rd_idx_q;
    case (state_q)
      IDLE: if (|full_d) begin
        // with both banks full the writer points at the older one
        state_d = FETCH;
        rd_bank_d = &full_d ? wr_bank_d : !full_d[0];
        rd_idx_d = '0;
      end
      FETCH: begin
        rd_en = 1'b1;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: if (last_acc) begin
        valid_d = 1'b0;
        state_d = full_d[!rd_bank_q] ? FETCH : IDLE;
        rd_bank_d = full_d[!rd_bank_q] ? !rd_bank_q : rd_bank_q;
        rd_idx_d = '0;
      end else if (acc) begin
        rd_idx_d = rd_idx_q + 1'b1;
        rd_en = 1'b1;
        rd_addr_idx = rd_idx_d;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full_q <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q <= '0;
      overflow_q <= 1'b0;
      state_q <= IDLE;
      rd_bank_q <= 1'b0;
      rd_idx_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      full_q <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q <= wr_cnt_d;
      overflow_q <= overflow_d;
      state_q <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q <= rd_idx_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  pingpong_ram #(.W(2 * bit_width), .AW(SIZE + 1)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr ({wr_bank_q, wr_ptr_i}),
    .wdata ({Re_i, Im_i}),
    .re    (rd_en),
    .raddr ({rd_bank_q, rd_addr_idx}),
    .rdata (rdata)
  );
  assign Re_o = rdata[2*bit_width-1:bit_width];
  assign Im_o = rdata[bit_width-1:0];
  assign idx_o = rd_idx_q;
  assign valid_o = valid_q;
  assign last_o = valid_q && rd_idx_q == SIZE'(N - 1);
  assign frame_done_o = done_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: directed vectors for reorder, backpressure, back-to-back, overflow, duplicates and reset
module tb_fft_output_reorder;
  logic clk = 1'b0;
  logic rst_n, valid_i, ready_i;
  logic signed [23:0] Re_i, Im_i, Re_o, Im_o;
  logic [3:0] wr_ptr_i, idx_o;
  logic valid_o, last_o, frame_done_o, overflow_o;
  int n_cmp = 0, n_bad = 0, gap = 0;
  int q_idx[$], q_re[$], q_im[$];
  bit stall = 0;
  logic [3:0] p_idx;
  logic signed [23:0] p_re, p_im;
  typedef struct {
    logic [3:0] ptr;
    int re_in;
    int im_in;
    int exp_idx;
    int exp_re;
    int exp_im;
  } vec_t;
  vec_t tbl[16];

  fft_output_reorder dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .Re_i(Re_i), .Im_i(Im_i),
    .wr_ptr_i(wr_ptr_i), .Re_o(Re_o), .Im_o(Im_o), .idx_o(idx_o), .valid_o(valid_o),
    .ready_i(ready_i), .last_o(last_o), .frame_done_o(frame_done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] bitrev(input int i);
    logic [3:0] b;
    b = 4'(i);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    Re_i = '0;
    Im_i = '0;
    wr_ptr_i = '0;
    tick();
    tick();
    rst_n = 1'b1;
    q_idx.delete();
    q_re.delete();
    q_im.delete();
    gap = 0;
  endtask

  task automatic put(input int p, input int re);
    valid_i = 1'b1;
    wr_ptr_i = 4'(p);
    Re_i = 24'(re);
    Im_i = 24'(-re);
    tick();
  endtask

  task automatic write_frame(input int base);
    for (int i = 0; i < 16; i++) put(bitrev(i), base + bitrev(i));
    valid_i = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    int c = 0;
    while (q_idx.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("wait_outputs", int'(q_idx.size() >= n), 1);
  endtask

  task automatic check_frames(input int n, input int b0, input int b1);
    chk("count", q_idx.size(), n);
    for (int k = 0; k < n && k < q_idx.size(); k++) begin
      chk("q_idx", q_idx[k], k % 16);
      chk("q_re", q_re[k], (k < 16 ? b0 : b1) + k % 16);
      chk("q_im", q_im[k], -((k < 16 ? b0 : b1) + k % 16));
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) stall = 0;
    else begin
      if (stall) chk("hold", int'(valid_o && idx_o == p_idx && Re_o == p_re && Im_o == p_im), 1);
      stall = valid_o && !ready_i;
      p_idx = idx_o;
      p_re = Re_o;
      p_im = Im_o;
      if (valid_o && ready_i) begin
        q_idx.push_back(int'(idx_o));
        q_re.push_back(int'(Re_o));
        q_im.push_back(int'(Im_o));
      end
      if (q_idx.size() > 0 && q_idx.size() < 32 && !valid_o) gap++;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].ptr = bitrev(i);
      tbl[i].re_in = int'(bitrev(i));
      tbl[i].im_in = -int'(bitrev(i));
      tbl[i].exp_idx = i;
      tbl[i].exp_re = i;
      tbl[i].exp_im = -i;
    end
    do_reset();
    chk("rst_valid", valid_o, 0);
    chk("rst_re", Re_o, 0);
    chk("rst_idx", idx_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_done", frame_done_o, 0);

    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      valid_i = 1'b1;
      wr_ptr_i = tbl[i].ptr;
      Re_i = 24'(tbl[i].re_in);
      Im_i = 24'(tbl[i].im_in);
      tick();
    end
    valid_i = 1'b0;
    chk("lat_early", valid_o, 0);
    tick();
    chk("latency", valid_o, 1);
    for (int i = 0; i < 16; i++) begin
      chk("idx", idx_o, tbl[i].exp_idx);
      chk("re", Re_o, tbl[i].exp_re);
      chk("im", Im_o, tbl[i].exp_im);
      chk("last", last_o, int'(i == 15));
      chk("valid_run", valid_o, 1);
      tick();
    end
    chk("done_pulse", frame_done_o, 1);
    chk("valid_end", valid_o, 0);
    tick();
    chk("done_clear", frame_done_o, 0);

    do_reset();
    write_frame(0);
    for (int c = 0; c < 200 && q_idx.size() < 16; c++) begin
      ready_i = ((c / 2) % 2) == 0;
      tick();
    end
    ready_i = 1'b1;
    repeat (10) tick();
    check_frames(16, 0, 0);

    do_reset();
    ready_i = 1'b1;
    write_frame(100);
    write_frame(200);
    wait_q(32, 100);
    repeat (5) tick();
    check_frames(32, 100, 200);
    chk("b2b_gap", gap, 1);
    chk("b2b_ovf", overflow_o, 0);

    do_reset();
    write_frame(100);
    write_frame(200);
    chk("ovf_before", overflow_o, 0);
    write_frame(300);
    chk("ovf_set", overflow_o, 1);
    ready_i = 1'b1;
    wait_q(32, 100);
    repeat (20) tick();
    check_frames(32, 100, 200);
    chk("ovf_sticky", overflow_o, 1);

    do_reset();
    ready_i = 1'b1;
    for (int b = 0; b < 16; b++) begin
      if (b == 6) continue;
      put(b, b == 5 ? 7 : b);
      if (b == 5) put(5, 9);
    end
    valid_i = 1'b0;
    wait_q(16, 60);
    repeat (10) tick();
    chk("dup_count", q_idx.size(), 16);
    if (q_idx.size() > 5) begin
      chk("dup_idx", q_idx[5], 5);
      chk("dup_re", q_re[5], 9);
      chk("dup_im", q_im[5], -9);
    end

    do_reset();
    ready_i = 1'b1;
    write_frame(30);
    for (int c = 0; c < 40 && !(valid_o && idx_o == 4'd7); c++) @(negedge clk);
    chk("mid_reached", idx_o, 7);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", valid_o, 0);
    chk("mr_re", Re_o, 0);
    chk("mr_im", Im_o, 0);
    chk("mr_idx", idx_o, 0);
    chk("mr_last", last_o, 0);
    @(posedge clk);
    #1;
    do_reset();
    ready_i = 1'b1;
    write_frame(60);
    wait_q(16, 60);
    repeat (10) tick();
    check_frames(16, 60, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
- Sink for the tagged sample stream produced by the last FFT stage: valid flag, Re/Im pair and bin address per sample.
- Samples arrive in scrambled order (bit-reversed or stage-dependent). The block writes each one into a ping-pong buffer at its bin address.
- Once a frame of N samples is complete, the block streams that frame out in natural bin order 0..N-1 over a valid/ready interface towards the UART/host side.
- It is the reading end of the stage output protocol.

Parameters:
- bit_width, 24, width of the Re and Im samples.
- N, 16, FFT points per frame; must be a power of 2.
- SIZE, 4, bin address width; equals log2(N).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  input sample strobe (stage en_o).
- Re_i  in  bit_width  real part, signed.
- Im_i  in  bit_width  imaginary part, signed.
- wr_ptr_i  in  SIZE  bin index of the current input sample.
- Re_o  out  bit_width  real part of the output sample, signed.
- Im_o  out  bit_width  imaginary part of the output sample, signed.
- idx_o  out  SIZE  bin index of the output sample.
- valid_o  out  1  output sample valid.
- ready_i  in  1  downstream accepts when high together with valid_o.
- last_o  out  1  high with valid_o when idx_o == N-1.
- frame_done_o  out  1  one-cycle pulse after the last sample of a frame is accepted.
- overflow_o  out  1  sticky flag: an input sample was dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, both banks empty, write bank = 0, read FSM IDLE. Reset mid-frame discards all buffered data. Buffer contents need not be cleared.
- Storage: 2 banks × N entries of {Re, Im}. Write is synchronous. Read is registered with 1-cycle latency.
- Write side:
  - valid_i=1 with the write bank not full: store at address wr_ptr_i in the write bank and increment the 0..N write count.
  - When the count reaches N, mark the bank full, toggle the write bank and reset the count. This happens in the same cycle as the Nth write.
  - A duplicate wr_ptr_i within one frame overwrites the entry (last write wins) and still counts.
  - valid_i=1 while the target write bank is still full (reader has not released it): drop the sample, set overflow_o, do not advance the count. overflow_o clears only on reset.
- Read FSM:
  - IDLE: when any bank is full, select the oldest full bank, set rd_idx=0, go to FETCH.
  - FETCH: issue the RAM read for rd_idx, go to SEND.
  - SEND: valid_o=1; Re_o/Im_o/idx_o stay stable until ready_i=1.
  - On acceptance with idx_o<N-1: increment rd_idx and issue the next read in the same cycle. valid_o stays high, so one sample per cycle under continuous ready.
  - On acceptance with idx_o==N-1: pulse frame_done_o next cycle and release the bank (empty). If the other bank is full, fetch its index 0 immediately, otherwise go to IDLE.
- Latency: first valid_o is 2 cycles after the cycle holding the Nth write (bank full at t, FETCH at t+1, valid_o at t+2).
- Back-to-back frames: reading frame k and writing frame k+1 proceed simultaneously.
- A bank released in the same cycle it is needed by the writer is writable in that cycle (release takes precedence).
- Handshake rules:
  - valid_o never drops without acceptance.
  - ready_i may toggle freely.
  - valid_o does not depend combinationally on ready_i.
- Arithmetic: no arithmetic on data. Re and Im pass through bit-exact, with sign preserved.

Decomposition:
- Shared package fft_pkg holds:
  - typedef sample_t {signed [bit_width-1:0] re, im}
  - read FSM state enum {IDLE, FETCH, SEND}
  - localparam BANKS=2
- One sub-module: pingpong_ram, a dual-bank simple dual-port RAM (one write port, one registered read port, bank-select bit prepended to the address). The FSM and counters stay in the top.

Test Plan:
- Single frame, ready_i=1: write bins in bit-reversed order 0,8,4,12,…,15 with Re=bin, Im=−bin → Re_o=0..15 and Im_o=0,−1,…,−15 in order; first valid_o 2 cycles after the last write; last_o at idx 15; frame_done_o one cycle later.
- Backpressure: same frame, ready_i toggled every 2 cycles → outputs held stable while ready_i=0, no skipped or repeated indices, exactly 16 acceptances.
- Back-to-back frames: frame A (Re=100+bin) then frame B (Re=200+bin) with no gap, ready_i=1 → 32 ordered outputs with no valid_o gap between idx 15 of A and idx 0 of B beyond the FETCH cycle; overflow_o stays 0.
- Overflow: ready_i=0, write 3 full frames → frames 1 and 2 fill the banks, all frame-3 samples are dropped and overflow_o=1; with ready_i then held at 1, only frames 1 and 2 are emitted.
- Duplicate pointer: in one frame bin 5 is written twice (Re=7, then Re=9) and bin 6 never → frame completes after 16 writes, idx 5 outputs Re=9.
- Reset mid-read: assert rst_n=0 at idx 7 of the output → all outputs 0 immediately; after release a fresh frame is output from idx 0 with no stale data.
